scope_capture_ctrl: RTL and testbench

- Consumer end of the trigger path: takes the 1-bit trigger level plus the sample stream, and writes one pre/post-trigger record into an external circular sample RAM.
- Sits between the trigger detector and the capture BRAM. Exports the trigger address and the record start address so the readout logic can unroll the circular buffer.
- Supports arm/abort, forced trigger, and a programmable pre-trigger length latched at arm.

---
 rtl/scope_capture_ctrl.sv | 155 +++++++++++++++
 tb/tb_scope_capture_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_capture_ctrl.sv
// Pre/post-trigger capture sequencer: streams samples into a circular RAM and
// records where the trigger landed so readout can unroll the buffer.
module scope_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic              trig_in,
  input  logic              force_trig,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pretrig_len,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              waiting,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_WAIT_TRIG,
    S_POSTTRIG,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_len_q, pre_len_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              trig_d_q, trig_d_d;
  logic              busy_q, busy_d;
  logic              waiting_q, waiting_d;
  logic              done_q, done_d;

  logic              capturing;
  logic              trig_edge;
  logic [ADDR_W-1:0] pre_last;
  logic [ADDR_W-1:0] post_last;

  assign capturing = (state_q == S_PRETRIG) || (state_q == S_WAIT_TRIG) ||
                     (state_q == S_POSTTRIG);
  assign trig_edge = en & ((trig_in & ~trig_d_q) | force_trig);
  assign pre_last  = pre_len_q - ADDR_W'(1);
  // Post phase holds DEPTH-pre_len samples; last count index taken mod DEPTH.
  assign post_last = ADDR_W'(0) - pre_len_q - ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    pre_len_d    = pre_len_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    trig_d_d     = en ? trig_in : trig_d_q;

    if (abort) begin
      state_d = S_IDLE;
    end else if (arm && !capturing) begin
      pre_len_d = pretrig_len;
      cnt_d     = '0;
      wr_ptr_d  = '0;
      state_d   = (pretrig_len != '0) ? S_PRETRIG : S_WAIT_TRIG;
    end else if (en && capturing) begin
      mem_we_d   = 1'b1;
      mem_addr_d = wr_ptr_q;
      mem_data_d = sample;
      wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
      case (state_q)
        S_PRETRIG: begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == pre_last) state_d = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (trig_edge) begin
            trig_addr_d  = wr_ptr_q;
            start_addr_d = wr_ptr_q - pre_len_q;
            cnt_d        = ADDR_W'(1);
            // With a single post sample the trigger write completes the record.
            state_d      = (post_last == '0) ? S_DONE : S_POSTTRIG;
          end
        end
        S_POSTTRIG: begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == post_last) state_d = S_DONE;
        end
        default: begin
        end
      endcase
    end

    busy_d    = (state_d == S_PRETRIG) || (state_d == S_WAIT_TRIG) ||
                (state_d == S_POSTTRIG);
    waiting_d = (state_d == S_WAIT_TRIG);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pre_len_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      trig_d_q     <= 1'b0;
      busy_q       <= 1'b0;
      waiting_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      pre_len_q    <= pre_len_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      trig_d_q     <= trig_d_d;
      busy_q       <= busy_d;
      waiting_q    <= waiting_d;
      done_q       <= done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign busy       = busy_q;
  assign waiting    = waiting_q;
  assign done       = done_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: expected RAM writes are queued as
// stimulus is applied and popped by an independent write monitor.
module tb_scope_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          trig_in = 1'b0;
  logic          force_trig = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pretrig_len = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;
  logic          busy;
  logic          waiting;
  logic          done;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [AW-1:0] exp_ptr = '0;

  scope_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .sample(sample), .trig_in(trig_in),
    .force_trig(force_trig), .arm(arm), .abort(abort), .pretrig_len(pretrig_len),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .trig_addr(trig_addr), .start_addr(start_addr), .busy(busy),
    .waiting(waiting), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Write monitor: every RAM write must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t w;
    if (!rst && mem_we) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL spurious_write: addr=%0d data=%0d with none expected", mem_addr, mem_data);
      end else begin
        w = exp_q.pop_front();
        if (mem_addr == w.addr && mem_data == w.data) n_pass++;
        else $display("FAIL write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                      mem_addr, mem_data, w.addr, w.data);
      end
    end
  end

  task automatic step(input logic e, input int s, input logic tr, input logic fo,
                      input logic ar, input logic ab, input bit wr);
    en = e;
    sample = DW'(s);
    trig_in = tr;
    force_trig = fo;
    arm = ar;
    abort = ab;
    if (wr) begin
      exp_q.push_back('{addr: exp_ptr, data: DW'(s)});
      exp_ptr = exp_ptr + AW'(1);
    end
    @(posedge clk);
    #1;
    force_trig = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_arm(input int len);
    pretrig_len = AW'(len);
    exp_ptr = '0;
    step(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    step(1'b1, 999, trig_in, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 998, trig_in, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #2;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_start_addr", start_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_waiting", waiting, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Pre-trigger 4, ramp, trigger rises at sample 10 -> post samples 10..21.
    do_arm(4);
    chk("s1_busy_after_arm", busy, 1);
    for (int s = 0; s < 22; s++) begin
      step(1'b1, s, s >= 10, 1'b0, 1'b0, 1'b0, 1'b1);
      if (s == 2) chk("s1_pretrig_not_waiting", waiting, 0);
      if (s == 3) chk("s1_waiting", waiting, 1);
      if (s == 10) begin
        chk("s1_trig_addr", trig_addr, 10);
        chk("s1_start_addr", start_addr, 6);
        chk("s1_post_not_waiting", waiting, 0);
      end
      if (s == 20) chk("s1_not_done_early", done, 0);
    end
    chk("s1_done", done, 1);
    chk("s1_busy_clear", busy, 0);
    drain("s1_queue_empty");

    // Re-arm from DONE with zero pre-trigger, forced trigger, 16 post samples.
    do_arm(0);
    chk("s2_waiting_direct", waiting, 1);
    chk("s2_done_cleared", done, 0);
    for (int s = 100; s < 119; s++) begin
      step(1'b1, s, 1'b0, s == 103, 1'b0, 1'b0, 1'b1);
      if (s == 103) begin
        chk("s2_trig_addr", trig_addr, 3);
        chk("s2_start_addr", start_addr, 3);
      end
      if (s == 117) chk("s2_not_done_early", done, 0);
    end
    chk("s2_done", done, 1);
    drain("s2_queue_empty");

    // Pre-trigger 15: edge during PRETRIG ignored, next edge yields one post write.
    do_arm(15);
    for (int s = 200; s < 215; s++) begin
      step(1'b1, s, (s >= 205) && (s < 208), 1'b0, 1'b0, 1'b0, 1'b1);
      if (s == 206) begin
        chk("s3_pretrig_busy", busy, 1);
        chk("s3_pretrig_not_waiting", waiting, 0);
      end
    end
    chk("s3_waiting", waiting, 1);
    step(1'b1, 215, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 216, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s3_done", done, 1);
    chk("s3_trig_addr", trig_addr, 0);
    chk("s3_start_addr", start_addr, 1);
    drain("s3_queue_empty");

    // Pre-trigger 12, en toggling during POSTTRIG with trig_in held high.
    do_arm(12);
    for (int s = 300; s < 312; s++) step(1'b1, s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 312, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s4_trig_addr", trig_addr, 12);
    chk("s4_start_addr", start_addr, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 777, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("s4_busy_en_low", busy, 1);
      step(1'b1, 313 + k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (k == 1) chk("s4_not_done_early", done, 0);
    end
    chk("s4_done", done, 1);
    chk("s4_trig_addr_hold", trig_addr, 12);
    drain("s4_queue_empty");

    // Lost force on en=0, arm while busy ignored, abort mid-POSTTRIG.
    do_arm(0);
    step(1'b1, 400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s5_force_en_low_lost", waiting, 1);
    step(1'b1, 401, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("s5_arm_busy_ignored", waiting, 1);
    step(1'b1, 402, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 403, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("s5_trig_addr", trig_addr, 3);
    step(1'b1, 404, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 405, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 406, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s5_abort_mem_we", mem_we, 0);
    chk("s5_abort_busy", busy, 0);
    chk("s5_abort_done", done, 0);
    chk("s5_abort_waiting", waiting, 0);
    chk("s5_abort_trig_hold", trig_addr, 3);
    chk("s5_abort_start_hold", start_addr, 3);
    drain("s5_queue_empty");

    // Long WAIT_TRIG (40 samples) so the write pointer wraps before the trigger.
    do_arm(4);
    for (int s = 500; s < 544; s++) step(1'b1, s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s6_still_waiting", waiting, 1);
    step(1'b1, 544, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s6_trig_addr", trig_addr, 12);
    chk("s6_start_addr", start_addr, 8);
    for (int s = 545; s < 556; s++) begin
      step(1'b1, s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (s == 554) chk("s6_not_done_early", done, 0);
    end
    chk("s6_done", done, 1);
    drain("s6_queue_empty");

    // Asynchronous reset in the middle of WAIT_TRIG.
    do_arm(0);
    step(1'b1, 600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 601, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s7_pre_rst_we", mem_we, 1);
    chk("s7_pre_rst_addr", mem_addr, 1);
    chk("s7_pre_rst_data", mem_data, 601);
    #1 rst = 1'b1;
    #1;
    chk("s7_rst_mem_we", mem_we, 0);
    chk("s7_rst_mem_addr", mem_addr, 0);
    chk("s7_rst_mem_data", mem_data, 0);
    chk("s7_rst_trig_addr", trig_addr, 0);
    chk("s7_rst_start_addr", start_addr, 0);
    chk("s7_rst_busy", busy, 0);
    chk("s7_rst_waiting", waiting, 0);
    chk("s7_rst_done", done, 0);
    chk("s7_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
